// File: rtl/vga_plot_queue_if.sv
// Pixel plot port bundle shared by the MMU, the plot queue and the VGA adapter.
interface vga_plot_queue_if;
    logic [8:0]  in_x;
    logic [7:0]  in_y;
    logic [23:0] in_color;
    logic        in_plot;
    logic        in_full;
    logic        clear_req;
    logic [23:0] clear_color;
    logic        clear_busy;
    logic [8:0]  out_x;
    logic [7:0]  out_y;
    logic [23:0] out_color;
    logic        out_plot;
    logic        out_ready;
    logic        dropped;

    modport master (
        output in_x, in_y, in_color, in_plot, clear_req, clear_color, out_ready,
        input  in_full, clear_busy, out_x, out_y, out_color, out_plot, dropped
    );

    modport slave (
        input  in_x, in_y, in_color, in_plot, clear_req, clear_color, out_ready,
        output in_full, clear_busy, out_x, out_y, out_color, out_plot, dropped
    );
endinterface

// File: rtl/vga_plot_queue.sv
// Plot FIFO in front of a VGA adapter, with a whole-screen clear fill that
// takes priority over queued plots at beat boundaries.
module vga_plot_queue #(
    parameter int DEPTH = 8,
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239
) (
    input logic             clk,
    input logic             reset,
    vga_plot_queue_if.slave bus
);
    localparam int            PW         = $clog2(DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [8:0]    XM         = 9'(X_MAX);
    localparam logic [7:0]    YM         = 8'(Y_MAX);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
    state_t state;

    logic [40:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next, remain;
    logic          clear_pend;
    logic [23:0]   pend_color, take_color;
    logic [40:0]   head_next;
    logic          in_range, accept, push, beat, pop;
    logic          clear_take, start_clear, at_end;

    always_comb begin
        in_range    = (bus.in_x <= XM) && (bus.in_y <= YM);
        accept      = bus.in_plot && !bus.in_full;
        push        = accept && in_range;
        beat        = bus.out_plot && bus.out_ready;
        pop         = beat && (state == DRAIN);
        count_next  = count + CW'(push) - CW'(pop);
        remain      = count - CW'(pop);
        // Entry that will be at the head after this edge; bypass a same-cycle push
        // into an otherwise empty FIFO so draining sustains one beat per cycle.
        head_next   = (remain == '0) ? {bus.in_x, bus.in_y, bus.in_color}
                                     : mem[rd_ptr + PW'(pop)];
        clear_take  = clear_pend || bus.clear_req;
        take_color  = bus.clear_req ? bus.clear_color : pend_color;
        at_end      = (bus.out_x == XM) && (bus.out_y == YM);
        start_clear = clear_take && ((state == IDLE) || beat);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_x, bus.in_y, bus.in_color};
    end

    // In CLEAR the out_x/out_y registers double as the fill counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            clear_pend     <= 1'b0;
            pend_color     <= '0;
            bus.in_full    <= 1'b0;
            bus.dropped    <= 1'b0;
            bus.clear_busy <= 1'b0;
            bus.out_plot   <= 1'b0;
            bus.out_x      <= '0;
            bus.out_y      <= '0;
            bus.out_color  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count          <= count_next;
            bus.in_full    <= (count_next == FULL_COUNT);
            bus.dropped    <= accept && !in_range;
            clear_pend     <= clear_take && !start_clear;
            if (bus.clear_req) pend_color <= bus.clear_color;
            bus.clear_busy <= clear_take || ((state == CLEAR) && !(beat && at_end));

            if (start_clear) begin
                state         <= CLEAR;
                bus.out_x     <= '0;
                bus.out_y     <= '0;
                bus.out_color <= take_color;
                bus.out_plot  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (count != '0) begin
                            state        <= DRAIN;
                            bus.out_plot <= 1'b1;
                            {bus.out_x, bus.out_y, bus.out_color} <= head_next;
                        end
                    end
                    DRAIN: begin
                        if (beat) begin
                            if (count_next != '0) begin
                                {bus.out_x, bus.out_y, bus.out_color} <= head_next;
                            end else begin
                                state        <= IDLE;
                                bus.out_plot <= 1'b0;
                            end
                        end
                    end
                    CLEAR: begin
                        if (beat) begin
                            if (at_end) begin
                                if (count_next != '0) begin
                                    state <= DRAIN;
                                    {bus.out_x, bus.out_y, bus.out_color} <= head_next;
                                end else begin
                                    state        <= IDLE;
                                    bus.out_plot <= 1'b0;
                                end
                            end else if (bus.out_x == XM) begin
                                bus.out_x <= '0;
                                bus.out_y <= bus.out_y + 1'b1;
                            end else begin
                                bus.out_x <= bus.out_x + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        bus.out_plot <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vga_plot_queue.sv
// Bench for vga_plot_queue: directed vectors, FIFO/clear corner sequences and
// a randomized plot stream checked against a queue model.
module tb_vga_plot_queue;
    localparam int DEPTH = 8;
    localparam int X_MAX = 319;
    localparam int Y_MAX = 239;
    localparam int W     = X_MAX + 1;
    localparam int NPIX  = (X_MAX + 1) * (Y_MAX + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vga_plot_queue_if bus();

    vga_plot_queue #(.DEPTH(DEPTH), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [40:0] out_pix;
    assign out_pix = {bus.out_x, bus.out_y, bus.out_color};

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [23:0] c;
        logic        exp_plot;
        logic        exp_drop;
    } vec_t;

    function automatic logic [40:0] pix(input int x, input int y, input logic [23:0] c);
        return {9'(x), 8'(y), c};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.in_plot     = 1'b0;
        bus.in_x        = '0;
        bus.in_y        = '0;
        bus.in_color    = '0;
        bus.clear_req   = 1'b0;
        bus.clear_color = '0;
        bus.out_ready   = 1'b1;
    endtask

    task automatic set_plot(input int x, input int y, input logic [23:0] c);
        bus.in_x     = 9'(x);
        bus.in_y     = 8'(y);
        bus.in_color = c;
        bus.in_plot  = 1'b1;
    endtask

    // Called at a negedge; leaves reset released at a negedge.
    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        #1;
        check("rst_async_plot", bus.out_plot, 1'b0);
        check("rst_async_busy", bus.clear_busy, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_full", bus.in_full, 1'b0);
        check("rst_drop", bus.dropped, 1'b0);
        check("rst_pix", out_pix, 41'd0);
        reset = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [6];
        logic [40:0] q [$];
        logic [40:0] got [$];
        logic [40:0] last;
        logic        exp_drop, stall, found, seq_ok;
        int          run, beats, guard, err, gap, k, exp_k, highs;

        vt[0] = '{9'd5,   8'd7,   24'hFF0000, 1'b1, 1'b0};
        vt[1] = '{9'd320, 8'd0,   24'h123456, 1'b0, 1'b1};
        vt[2] = '{9'd319, 8'd239, 24'hABCDEF, 1'b1, 1'b0};
        vt[3] = '{9'd0,   8'd240, 24'h00FF00, 1'b0, 1'b1};
        vt[4] = '{9'd0,   8'd0,   24'h0000FF, 1'b1, 1'b0};
        vt[5] = '{9'd511, 8'd255, 24'hFFFFFF, 1'b0, 1'b1};

        set_idle();
        @(negedge clk);
        do_reset();

        // Single plots; the first one is applied in the first cycle out of reset.
        for (int i = 0; i < 6; i++) begin
            set_plot(int'(vt[i].x), int'(vt[i].y), vt[i].c);
            @(negedge clk);
            bus.in_plot = 1'b0;
            check($sformatf("vec%0d_drop", i), bus.dropped, vt[i].exp_drop);
            check($sformatf("vec%0d_early", i), bus.out_plot, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_plot", i), bus.out_plot, vt[i].exp_plot);
            if (vt[i].exp_plot)
                check($sformatf("vec%0d_pix", i), out_pix, pix(int'(vt[i].x), int'(vt[i].y), vt[i].c));
            @(negedge clk);
            check($sformatf("vec%0d_once", i), bus.out_plot, 1'b0);
            check($sformatf("vec%0d_drop_once", i), bus.dropped, 1'b0);
            @(negedge clk);
        end

        // Fill the FIFO under back-pressure, then drain it.
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_plot(i + 1, i + 2, 24'h100000 + 24'(i));
            @(negedge clk);
        end
        check("full_flag", bus.in_full, 1'b1);
        set_plot(100, 100, 24'h999999);
        @(negedge clk);
        bus.in_plot = 1'b0;
        check("full_hold", bus.in_full, 1'b1);
        bus.out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 30; c++) begin
            if (bus.out_plot && bus.out_ready) got.push_back(out_pix);
            @(negedge clk);
        end
        check("full_beats", got.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < got.size(); i++)
            check($sformatf("full_order%0d", i), got[i], pix(i + 1, i + 2, 24'h100000 + 24'(i)));
        check("full_release", bus.in_full, 1'b0);
        check("full_idle", bus.out_plot, 1'b0);

        // Randomized plot stream against an in-order queue model.
        do_reset();
        q.delete();
        exp_drop = 1'b0;
        stall    = 1'b0;
        last     = '0;
        run      = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.in_plot   = ($urandom_range(0, 99) < 45);
            bus.in_x      = 9'($urandom_range(0, 330));
            bus.in_y      = 8'($urandom_range(0, 245));
            bus.in_color  = 24'($urandom);
            bus.out_ready = ($urandom_range(0, 99) < (((cyc / 500) % 2 == 0) ? 90 : 20));
            check("rnd_full", bus.in_full, (q.size() == DEPTH));
            check("rnd_drop", bus.dropped, exp_drop);
            if (stall) check("rnd_stable", out_pix, last);
            if (bus.out_plot) check("rnd_nonempty", (q.size() != 0), 1'b1);
            run = (q.size() != 0 && !bus.out_plot) ? run + 1 : 0;
            if (q.size() != 0) check("rnd_live", (run <= 3), 1'b1);
            if (bus.out_plot && bus.out_ready && q.size() != 0) begin
                check("rnd_beat", out_pix, q[0]);
                void'(q.pop_front());
            end
            exp_drop = 1'b0;
            if (bus.in_plot && !bus.in_full) begin
                if (int'(bus.in_x) <= X_MAX && int'(bus.in_y) <= Y_MAX)
                    q.push_back({bus.in_x, bus.in_y, bus.in_color});
                else
                    exp_drop = 1'b1;
            end
            stall = bus.out_plot && !bus.out_ready;
            last  = out_pix;
            @(negedge clk);
        end
        bus.in_plot   = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_plot && q.size() != 0) begin
                check("rnd_drain", out_pix, q[0]);
                void'(q.pop_front());
            end
            @(negedge clk);
        end
        check("rnd_empty", q.size(), 0);
        check("rnd_idle", bus.out_plot, 1'b0);

        // Full-screen clear with one plot queued part-way through.
        bus.clear_color = 24'h0000FF;
        bus.clear_req   = 1'b1;
        @(negedge clk);
        bus.clear_req   = 1'b0;
        bus.clear_color = 24'h000000;
        check("clr_busy_rise", bus.clear_busy, 1'b1);
        beats = 0; guard = 0; err = 0; gap = 0;
        while (beats < NPIX && guard < NPIX + 100) begin
            if (bus.out_plot) begin
                if (out_pix !== pix(beats % W, beats / W, 24'h0000FF)) err++;
                if (!bus.clear_busy) err++;
                if (beats == 500) set_plot(10, 10, 24'h00FF00);
                beats++;
            end else if (beats > 0) begin
                gap++;
            end
            @(negedge clk);
            bus.in_plot = 1'b0;
            guard++;
        end
        check("clr_count", beats, NPIX);
        check("clr_seq", err, 0);
        check("clr_gap", gap, 0);
        check("clr_busy_fall", bus.clear_busy, 1'b0);
        check("clr_after_plot", bus.out_plot, 1'b1);
        check("clr_after_pix", out_pix, pix(10, 10, 24'h00FF00));
        @(negedge clk);
        check("clr_after_once", bus.out_plot, 1'b0);

        // A second clear_req mid-fill restarts from the origin with the new colour.
        bus.clear_color = 24'hAAAAAA;
        bus.clear_req   = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        k = 0; guard = 0;
        while (k <= 100 && guard < 500) begin
            if (bus.out_plot) begin
                if (k == 100) begin
                    bus.clear_req   = 1'b1;
                    bus.clear_color = 24'h555555;
                end
                k++;
            end
            @(negedge clk);
            bus.clear_req = 1'b0;
            guard++;
        end
        check("restart_reach", k, 101);
        found = 1'b0; seq_ok = 1'b1; exp_k = 101; guard = 0;
        while (!found && guard < 6) begin
            if (bus.out_plot) begin
                if (bus.out_color == 24'h555555) begin
                    found = 1'b1;
                    check("restart_origin", out_pix, pix(0, 0, 24'h555555));
                end else begin
                    if (out_pix !== pix(exp_k % W, exp_k / W, 24'hAAAAAA)) seq_ok = 1'b0;
                    exp_k++;
                end
            end
            if (!found) @(negedge clk);
            guard++;
        end
        check("restart_found", found, 1'b1);
        check("restart_prior_seq", seq_ok, 1'b1);
        @(negedge clk);
        check("restart_next", out_pix, pix(1, 0, 24'h555555));

        // Reset at clear beat 1000 with a plot queued: everything is lost.
        do_reset();
        bus.clear_color = 24'h0000FF;
        bus.clear_req   = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        k = 0; guard = 0;
        while (k < 1000 && guard < 2000) begin
            if (bus.out_plot) begin
                if (k == 10) set_plot(10, 10, 24'h00FF00);
                k++;
            end
            @(negedge clk);
            bus.in_plot = 1'b0;
            guard++;
        end
        check("abort_reach", k, 1000);
        check("abort_beat_live", bus.out_plot, 1'b1);
        do_reset();
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_plot) highs++;
            @(negedge clk);
        end
        check("abort_no_residual", highs, 0);
        check("abort_busy", bus.clear_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
